// File: rtl/rotmul_pkg.sv
// -----------------------------------------------------------------------------
// rotmul_pkg
// Shared definitions for the rotate-multiply-store engine:
//   - rot_mode_t : rotation mode encodings carried with each beat
//   - state_t    : engine control states (IDLE / DRAIN / CLEAR)
//   - rotl_var   : width-generic left rotate used by the datapath
// No ports (package).
// -----------------------------------------------------------------------------
package rotmul_pkg;

    // Widest operand the rotate helper supports.
    localparam int MAXW = 32;

    typedef enum logic [1:0] {
        ROT_L1   = 2'd0,
        ROT_ALT  = 2'd1,
        ROT_VAR  = 2'd2,
        ROT_NONE = 2'd3
    } rot_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Rotate the low w bits of x left by (n mod w). Bits above w are zero.
    // Works in a double-width word so that w == MAXW needs no special case;
    // an amount of 0 shifts right by w, which contributes nothing.
    function automatic logic [MAXW-1:0] rotl_var(input logic [MAXW-1:0] x,
                                                 input int unsigned     w,
                                                 input int unsigned     n);
        logic [2*MAXW-1:0] mask;
        logic [2*MAXW-1:0] wide;
        int unsigned       s;
        s    = n % w;
        mask = {(2*MAXW){1'b1}} >> (2*MAXW - w);
        wide = (2*MAXW)'(x) & mask;
        wide = ((wide << s) | (wide >> (w - s))) & mask;
        return wide[MAXW-1:0];
    endfunction

endpackage

// File: rtl/rotmul_regfile.sv
// -----------------------------------------------------------------------------
// rotmul_regfile
// DEPTH x 2W register file with one datapath write port, one clear write
// port (zeroes an entry, takes priority) and a write-first synchronous read.
// Optional macro ROTMUL_ACCUM_EN: the datapath write becomes a saturating
// read-modify-write (entry = min(entry + data, 2^(2W)-1)).
// Ports:
//   clk, rst_n          clock, async active-low reset (clears all entries)
//   wr_en/addr/data     datapath write (product)
//   clr_en/clr_addr     zero one entry
//   rd_en/rd_addr       read request; rd_data/rd_valid registered result
// -----------------------------------------------------------------------------
module rotmul_regfile #(
    parameter int W     = 4,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [2*W-1:0]  wr_data,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [2*W-1:0]  rd_data,
    output logic            rd_valid
);

    logic [2*W-1:0] mem [DEPTH];
    logic           upd_en;
    logic [AW-1:0]  upd_addr;
    logic [2*W-1:0] upd_val;

`ifdef ROTMUL_ACCUM_EN
    function automatic logic [2*W-1:0] sat_add(input logic [2*W-1:0] a,
                                               input logic [2*W-1:0] b);
        logic [2*W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[2*W] ? {(2*W){1'b1}} : s[2*W-1:0];
    endfunction
`endif

    // Single merged update; the accumulate path reads the entry in the same
    // cycle it writes, so consecutive beats to one address never see stale data.
    always_comb begin
        upd_en   = wr_en || clr_en;
        upd_addr = clr_en ? clr_addr : wr_addr;
        if (clr_en) begin
            upd_val = '0;
        end else begin
`ifdef ROTMUL_ACCUM_EN
            upd_val = sat_add(mem[wr_addr], wr_data);
`else
            upd_val = wr_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (upd_en) begin
                mem[upd_addr] <= upd_val;
            end
            rd_valid <= rd_en;
            if (rd_en) begin
                // Write-first: a same-edge update to the read address is forwarded.
                rd_data <= (upd_en && (upd_addr == rd_addr)) ? upd_val : mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/rotmul_store_engine.sv
// -----------------------------------------------------------------------------
// rotmul_store_engine
// Pipelined rotate-multiply-store engine. Each accepted (num, key, addr) beat
// is rotated left per rot_mode, multiplied by key (full 2W-bit product) and
// written to file[addr] two edges after acceptance. A clear sequencer drains
// the pipeline and zeroes every entry, then pulses clr_done.
// Optional macro ROTMUL_ACCUM_EN (in rotmul_regfile): saturating accumulate.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready             beat handshake (in_ready = state is IDLE)
//   in_num, in_key, in_addr       beat operands and destination
//   rot_mode, rot_amt             rotation select / variable amount
//   clr_req, clr_done             clear request / completion pulse
//   rd_en, rd_addr                read request
//   rd_data, rd_valid             read result (write-first)
// -----------------------------------------------------------------------------
module rotmul_store_engine
    import rotmul_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int RW    = $clog2(W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_num,
    input  logic [W-1:0]    in_key,
    input  logic [AW-1:0]   in_addr,
    input  logic [1:0]      rot_mode,
    input  logic [RW-1:0]   rot_amt,
    input  logic            clr_req,
    output logic            clr_done,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [2*W-1:0]  rd_data,
    output logic            rd_valid
);

    state_t         state_q, state_d;
    logic           accept;
    logic           toggle;
    logic [AW-1:0]  cnt;
    logic           clr_active;
    logic           clr_last;

    logic           vld_p1;
    logic [W-1:0]   num_p1;
    logic [W-1:0]   key_p1;
    logic [AW-1:0]  addr_p1;
    rot_mode_t      mode_p1;
    logic [RW-1:0]  amt_p1;

    logic           vld_p2;
    logic [W-1:0]   rot_p2;
    logic [W-1:0]   key_p2;
    logic [AW-1:0]  addr_p2;

    int unsigned    rot_n;
    logic [W-1:0]   rot_c;
    logic [2*W-1:0] prod;

    assign in_ready   = (state_q == IDLE);
    assign accept     = in_valid && in_ready;
    assign clr_active = (state_q == CLEAR);
    assign clr_last   = clr_active && (cnt == AW'(DEPTH - 1));

    // ---- control state: FSM, valids, toggle, clear counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            toggle   <= 1'b0;
            cnt      <= '0;
            clr_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            vld_p1   <= accept;
            vld_p2   <= vld_p1;
            clr_done <= clr_last;
            // Toggle advances as an alternating-mode beat moves S1 -> S2.
            if (clr_last) begin
                toggle <= 1'b0;
            end else if (vld_p1 && (mode_p1 == ROT_ALT)) begin
                toggle <= ~toggle;
            end
            if (clr_active) begin
                cnt <= clr_last ? '0 : cnt + AW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_req) state_d = DRAIN;
            DRAIN:   if (!vld_p1 && !vld_p2) state_d = CLEAR;
            CLEAR:   if (clr_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- stage 1: capture beat ----
    always_ff @(posedge clk) begin
        if (accept) begin
            num_p1  <= in_num;
            key_p1  <= in_key;
            addr_p1 <= in_addr;
            mode_p1 <= rot_mode_t'(rot_mode);
            amt_p1  <= rot_amt;
        end
    end

    always_comb begin
        rot_n = 0;
        case (mode_p1)
            ROT_L1:   rot_n = 1;
            ROT_ALT:  rot_n = toggle ? 2 : 1;
            ROT_VAR:  rot_n = 32'(amt_p1);
            ROT_NONE: rot_n = 0;
            default:  rot_n = 0;
        endcase
        rot_c = W'(rotl_var(MAXW'(num_p1), W, rot_n));
    end

    // ---- stage 2: register rotated operand ----
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            rot_p2  <= rot_c;
            key_p2  <= key_p1;
            addr_p2 <= addr_p1;
        end
    end

    // ---- stage 3: multiply and write into the file ----
    assign prod = (2*W)'(key_p2) * (2*W)'(rot_p2);

    rotmul_regfile #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (vld_p2),
        .wr_addr  (addr_p2),
        .wr_data  (prod),
        .clr_en   (clr_active),
        .clr_addr (cnt),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule
